// File: rtl/ram_dma_if.sv
// ram_dma_if: bundles the command, write-stream, read-stream and RAM port signals
// of the RAM block-transfer engine.
//   cmd_*    : block command handshake (write/read select, start address, length-1)
//   wr_*     : byte stream into RAM (valid/ready)
//   rd_*     : byte stream out of RAM (valid/ready)
//   ram_*    : single-port RAM bus, read data valid one cycle after the address
// Modports: master = the DMA engine, slave = the surrounding system.
interface ram_dma_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [ADDR_W-1:0] cmd_len;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_w_en;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len,
        input  wr_valid, wr_data, rd_ready, ram_dout,
        output cmd_ready, wr_ready, rd_valid, rd_data,
        output ram_addr, ram_w_en, ram_din
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_len,
        output wr_valid, wr_data, rd_ready, ram_dout,
        input  cmd_ready, wr_ready, rd_valid, rd_data,
        input  ram_addr, ram_w_en, ram_din
    );
endinterface

// File: rtl/ram_dma.sv
// ram_dma: bus initiator for the system RAM port. Executes one block command at
// a time: WRITE copies bytes from the write stream into RAM, READ copies RAM bytes
// to the read stream through a 2-entry output FIFO. Used for serial program
// load/dump while the CPU is held off the RAM port.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : ram_dma_if.master (command, write stream, read stream, RAM bus)
//   busy  : high from command accept until the done pulse
//   done  : one-cycle pulse when a command has fully completed
module ram_dma #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    ram_dma_if.master     bus,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr;          // next RAM address to touch
    logic [ADDR_W-1:0] remaining;     // beats left after the current one
    logic [ADDR_W-1:0] ram_addr_q;
    logic [DATA_W-1:0] ram_din_q;
    logic              ram_w_en_q;
    logic              wr_ready_q;
    logic              inflight;      // read issued last cycle, data on ram_dout now
    logic [DATA_W-1:0] fifo_mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;

    logic pop;
    logic push;
    logic issue;
    logic wr_beat;

    assign pop     = (count != 2'd0) && bus.rd_ready;
    assign push    = inflight;
    assign wr_beat = (state == WRITE) && bus.wr_valid && wr_ready_q;

    // Every issued read must have a FIFO slot even if the sink never pops again.
    // Counting this cycle's pop is what lets a steady stream run at one byte per
    // clock with only two entries.
    assign issue = (state == READ) &&
                   (({1'b0, count} + {2'b00, inflight}) <= (3'd1 + {2'b00, pop}));

    assign bus.cmd_ready = ~busy;
    assign bus.wr_ready  = wr_ready_q;
    assign bus.rd_valid  = (count != 2'd0);
    assign bus.rd_data   = fifo_mem[rd_ptr];
    // Reads present the address in the issue cycle so data lands one cycle later;
    // otherwise the last used address is held.
    assign bus.ram_addr  = issue ? addr : ram_addr_q;
    assign bus.ram_w_en  = ram_w_en_q;
    assign bus.ram_din   = ram_din_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            addr        <= '0;
            remaining   <= '0;
            ram_addr_q  <= '0;
            ram_din_q   <= '0;
            ram_w_en_q  <= 1'b0;
            wr_ready_q  <= 1'b0;
            inflight    <= 1'b0;
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            count       <= 2'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            ram_w_en_q <= 1'b0;
            done       <= 1'b0;
            inflight   <= issue;

            // Output FIFO: push and pop may coincide; count then stays put.
            if (push) begin
                fifo_mem[wr_ptr] <= bus.ram_dout;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};

            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        addr      <= bus.cmd_addr;
                        remaining <= bus.cmd_len;
                        busy      <= 1'b1;
                        if (bus.cmd_write) begin
                            state      <= WRITE;
                            wr_ready_q <= 1'b1;
                        end else begin
                            state <= READ;
                        end
                    end
                end

                WRITE: begin
                    if (wr_beat) begin
                        ram_addr_q <= addr;
                        ram_din_q  <= bus.wr_data;
                        ram_w_en_q <= 1'b1;
                        addr       <= addr + 1'b1;
                        remaining  <= remaining - 1'b1;
                        // Last beat: done rises together with its write strobe.
                        if (remaining == '0) begin
                            wr_ready_q <= 1'b0;
                            done       <= 1'b1;
                            busy       <= 1'b0;
                            state      <= IDLE;
                        end
                    end
                end

                READ: begin
                    if (issue) begin
                        ram_addr_q <= addr;
                        addr       <= addr + 1'b1;
                        remaining  <= remaining - 1'b1;
                        if (remaining == '0) begin
                            state <= DRAIN;
                        end
                    end
                end

                DRAIN: begin
                    // Finish on the edge that pops the final byte, so done is
                    // high the cycle right after the last read handshake.
                    if (!inflight && (count == {1'b0, pop})) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_dma.sv
module tb_ram_dma;
    localparam int ADDR_W = 13;
    localparam int DATA_W = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic busy;
    logic done;

    ram_dma_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    ram_dma #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: read data appears the cycle after the address.
    logic [DATA_W-1:0] mem [8192];
    always @(posedge clk) begin
        if (bus.ram_w_en) mem[bus.ram_addr] <= bus.ram_din;
        bus.ram_dout <= mem[bus.ram_addr];
    end

    typedef struct {
        bit          wr;
        logic [12:0] addr;
        logic [12:0] len;
        logic [7:0]  base;
        int          gap_max;
        bit          rnd_rdy;
        bit          chk_rate;
        int          exp_beats;
    } vec_t;

    typedef struct {
        logic [12:0] a;
        logic [7:0]  d;
    } wexp_t;

    vec_t        vecs [8];
    wexp_t       wq [$];
    logic [7:0]  rq [$];
    logic [7:0]  shadow [8192];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_cnt = 0;
    int beats_seen = 0;
    int acc_cyc, first_valid_cyc, first_hs_cyc, last_hs_cyc;
    bit cmd_acc, wr_acc, rd_hs, cur_write, prev_last;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: sample/score at negedge, then return just after the next posedge.
    task automatic tick();
        wexp_t w;
        logic [7:0] e;
        @(negedge clk);
        cyc++;
        cmd_acc = bus.cmd_valid && bus.cmd_ready;
        wr_acc  = bus.wr_valid && bus.wr_ready;
        rd_hs   = bus.rd_valid && bus.rd_ready;
        if (bus.rd_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (bus.ram_w_en === 1'b1) begin
            beats_seen++;
            chk("strobe_expected", 32'(wq.size() > 0), 1);
            if (wq.size() > 0) begin
                w = wq.pop_front();
                chk("strobe_addr", 32'(bus.ram_addr), 32'(w.a));
                chk("strobe_data", 32'(bus.ram_din), 32'(w.d));
            end
        end
        if (done === 1'b1) begin
            done_cnt++;
            if (cur_write) begin
                chk("done_with_last_strobe", 32'(bus.ram_w_en), 1);
                chk("done_write_queue_empty", 32'(wq.size()), 0);
            end else begin
                chk("done_after_last_rd", 32'(prev_last), 1);
            end
        end
        prev_last = rd_hs && (rq.size() == 1);
        if (rd_hs) begin
            beats_seen++;
            chk("rd_expected", 32'(rq.size() > 0), 1);
            if (rq.size() > 0) begin
                e = rq.pop_front();
                chk("rd_data", 32'(bus.rd_data), 32'(e));
            end
            if (first_hs_cyc < 0) first_hs_cyc = cyc;
            last_hs_cyc = cyc;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic start_cmd(input bit wr, input logic [12:0] a, input logic [12:0] len);
        int n;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = a;
        bus.cmd_len   = len;
        n = 0;
        do begin
            tick();
            n++;
        end while (!cmd_acc && n < 20);
        chk("cmd_accept", 32'(cmd_acc), 1);
        acc_cyc = cyc;
    endtask

    task automatic run_cmd(input vec_t v);
        int n;
        int gaps;
        logic [12:0] a;
        cur_write       = v.wr;
        done_cnt        = 0;
        beats_seen      = 0;
        first_valid_cyc = -1;
        first_hs_cyc    = -1;
        last_hs_cyc     = -1;
        // Scoreboard: expected strobes/bytes pushed as the command is set up.
        for (int i = 0; i <= int'(v.len); i++) begin
            a = v.addr + 13'(i);
            if (v.wr) begin
                wq.push_back('{a: a, d: v.base + 8'(i)});
                shadow[a] = v.base + 8'(i);
            end else begin
                rq.push_back(shadow[a]);
            end
        end
        bus.rd_ready = 1'b1;
        start_cmd(v.wr, v.addr, v.len);
        bus.cmd_valid = 1'b0;
        chk("busy_after_accept", 32'(busy), 1);
        if (v.wr) begin
            for (int i = 0; i <= int'(v.len); i++) begin
                gaps = (v.gap_max > 0) ? int'($urandom_range(0, v.gap_max)) : 0;
                bus.wr_valid = 1'b0;
                repeat (gaps) tick();
                bus.wr_valid = 1'b1;
                bus.wr_data  = v.base + 8'(i);
                n = 0;
                do begin
                    tick();
                    n++;
                end while (!wr_acc && n < 20);
                chk("wr_accept", 32'(wr_acc), 1);
            end
            bus.wr_valid = 1'b0;
        end
        n = 0;
        while (done_cnt == 0 && n < 200) begin
            if (v.rnd_rdy) bus.rd_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        bus.rd_ready = 1'b1;
        chk("done_seen", 32'(done_cnt), 1);
        tick();
        tick();
        chk("single_done", 32'(done_cnt), 1);
        chk("busy_after_done", 32'(busy), 0);
        chk("beats", 32'(beats_seen), 32'(v.exp_beats));
        chk("queue_drained", 32'(wq.size() + rq.size()), 0);
        if (v.chk_rate) begin
            // Accept is sampled in the cycle before its edge, hence the minus one.
            chk("rd_latency_clocks", 32'(first_valid_cyc - acc_cyc - 1), 2);
            chk("rd_back_to_back", 32'(last_hs_cyc - first_hs_cyc), 32'(v.len));
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 1);
        chk({tag, "_wr_ready"},  32'(bus.wr_ready), 0);
        chk({tag, "_rd_valid"},  32'(bus.rd_valid), 0);
        chk({tag, "_rd_data"},   32'(bus.rd_data), 0);
        chk({tag, "_ram_addr"},  32'(bus.ram_addr), 0);
        chk({tag, "_ram_w_en"},  32'(bus.ram_w_en), 0);
        chk({tag, "_ram_din"},   32'(bus.ram_din), 0);
        chk({tag, "_busy"},      32'(busy), 0);
        chk({tag, "_done"},      32'(done), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.wr_valid  = 1'b0;
        bus.wr_data   = '0;
        bus.rd_ready  = 1'b0;

        //          wr    addr      len    base   gap rnd rate beats
        vecs[0] = '{1'b1, 13'h0100, 13'd3, 8'hA0, 0, 1'b0, 1'b0, 4};
        vecs[1] = '{1'b0, 13'h0100, 13'd3, 8'h00, 0, 1'b0, 1'b1, 4};
        vecs[2] = '{1'b1, 13'h0200, 13'd7, 8'h30, 5, 1'b0, 1'b0, 8};
        vecs[3] = '{1'b0, 13'h0200, 13'd7, 8'h00, 0, 1'b1, 1'b0, 8};
        vecs[4] = '{1'b1, 13'h1FFE, 13'd3, 8'hC0, 2, 1'b0, 1'b0, 4};
        vecs[5] = '{1'b0, 13'h1FFE, 13'd3, 8'h00, 0, 1'b1, 1'b0, 4};
        vecs[6] = '{1'b1, 13'h0050, 13'd0, 8'h5A, 0, 1'b0, 1'b0, 1};
        vecs[7] = '{1'b0, 13'h0050, 13'd0, 8'h00, 0, 1'b0, 1'b1, 1};

        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("por");
        rst_n = 1'b1;
        tick();
        tick();

        for (int i = 0; i < 8; i++) run_cmd(vecs[i]);

        // Reset in the middle of a READ with the output FIFO full.
        cur_write       = 1'b0;
        done_cnt        = 0;
        first_valid_cyc = -1;
        first_hs_cyc    = -1;
        bus.rd_ready    = 1'b0;
        for (int i = 0; i < 8; i++) rq.push_back(shadow[13'h0200 + 13'(i)]);
        start_cmd(1'b0, 13'h0200, 13'd7);
        // Keep offering a different command: it must be ignored while busy.
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 13'h0777;
        repeat (5) tick();
        chk("not_accepted_while_busy", 32'(cmd_acc), 0);
        chk("cmd_ready_while_busy", 32'(bus.cmd_ready), 0);
        chk("fifo_full_rd_valid", 32'(bus.rd_valid), 1);
        bus.cmd_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        rq.delete();
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("no_done_after_reset", 32'(done_cnt), 0);

        run_cmd(vecs[1]);
        run_cmd(vecs[4]);
        run_cmd(vecs[5]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
